// File: rtl/xadc_chan_poller.sv
// xadc_chan_poller
// Multi-channel XADC sampling engine. Every end-of-conversion on a channel in
// [BASE_CH, BASE_CH+NUM_CH-1] triggers one DRP read of that channel's status
// register. The read value is optionally box-car averaged over 2^AVG_LOG2
// samples and then held per slot, with sticky out-of-window alarms.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no read in flight; serve pending EOC first, else live EOC
//   REQ     | drive den_out/daddr_out for one cycle, load DRP timeout
//   WAIT    | wait for drdy_in; abandon the read when the timeout expires
//   ACC     | accumulate the sample, write the result on the last sample
//
// One EOC can be parked while a read is in flight. A further EOC in that
// window is lost and counted in overrun_cnt.

module xadc_chan_poller #(
   parameter int NUM_CH   = 4,
   parameter int BASE_CH  = 16,
   parameter int ADC_BITS = 12,
   parameter int AVG_LOG2 = 0,
   parameter int TIMEOUT  = 64
) (
   input  logic                       dclk_in,
   input  logic                       reset_in,
   input  logic                       eoc_in,
   input  logic [4:0]                 channel_in,
   output logic                       den_out,
   output logic [6:0]                 daddr_out,
   output logic                       dwe_out,
   output logic [15:0]                di_out,
   input  logic [15:0]                do_in,
   input  logic                       drdy_in,
   input  logic [ADC_BITS-1:0]        thr_hi,
   input  logic [ADC_BITS-1:0]        thr_lo,
   input  logic                       alarm_clr,
   output logic [NUM_CH*ADC_BITS-1:0] result_flat,
   output logic                       valid_out,
   output logic [3:0]                 valid_ch,
   output logic [ADC_BITS-1:0]        valid_data,
   output logic [NUM_CH-1:0]          alarm_out,
   output logic                       busy_out,
   output logic                       timeout_out,
   output logic [7:0]                 overrun_cnt
);

   // slot index width, accumulator width, sample-count width, timer width
   localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW = ADC_BITS + AVG_LOG2;
   localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
   localparam logic [5:0]    CH_FIRST = 6'(BASE_CH);
   localparam logic [5:0]    CH_LAST  = 6'(BASE_CH + NUM_CH - 1);
   localparam logic [4:0]    CH_BASE5 = 5'(BASE_CH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_ACC  = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [4:0]          ch_q;
   logic                pend_vld_q;
   logic [4:0]          pend_ch_q;
   logic [TW-1:0]       tmo_q;
   logic [ADC_BITS-1:0] sample_q;

   logic [AW-1:0]       acc_q [NUM_CH];
   logic [CW-1:0]       cnt_q [NUM_CH];
   logic [ADC_BITS-1:0] res_q [NUM_CH];

   logic                eoc_hit;
   logic                take_pend;
   logic                take_live;
   logic                tmo_hit;
   logic [SW-1:0]       slot;
   logic [AW-1:0]       acc_sum;
   logic [ADC_BITS-1:0] avg_val;
   logic                avg_last;
   logic                res_wr;
   logic [NUM_CH-1:0]   alarm_set;

   // Out-of-range channels are filtered at the door so they never occupy
   // the pending slot and never count as overruns.
   assign eoc_hit = eoc_in
                    && ({1'b0, channel_in} >= CH_FIRST)
                    && ({1'b0, channel_in} <= CH_LAST);

   assign slot = SW'(ch_q - CH_BASE5);

   // Next-state logic and IDLE arbitration between pending and live EOCs
   always_comb begin
      state_d   = state_q;
      take_pend = 1'b0;
      take_live = 1'b0;
      tmo_hit   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_vld_q) begin
               take_pend = 1'b1;
               state_d   = ST_REQ;
            end else if (eoc_hit) begin
               take_live = 1'b1;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (drdy_in) begin
               state_d = ST_ACC;
            end else if (tmo_q == '0) begin
               tmo_hit = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ACC: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge dclk_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign den_out     = (state_q == ST_REQ);
   assign busy_out    = (state_q != ST_IDLE);
   assign timeout_out = tmo_hit;
   assign daddr_out   = {2'b00, ch_q};
   assign dwe_out     = 1'b0;
   assign di_out      = '0;

   // Latch the channel being served and manage the one-deep pending slot
   always_ff @(posedge dclk_in) begin
      if (reset_in) begin
         ch_q        <= '0;
         pend_vld_q  <= 1'b0;
         pend_ch_q   <= '0;
         overrun_cnt <= '0;
      end else begin
         if (take_pend) begin
            ch_q <= pend_ch_q;
         end else if (take_live) begin
            ch_q <= channel_in;
         end

         if (state_q == ST_IDLE) begin
            // pending is consumed this cycle, so a live EOC can take its place
            if (pend_vld_q) begin
               pend_vld_q <= eoc_hit;
               if (eoc_hit) begin
                  pend_ch_q <= channel_in;
               end
            end
         end else if (eoc_hit) begin
            if (!pend_vld_q) begin
               pend_vld_q <= 1'b1;
               pend_ch_q  <= channel_in;
            end else if (overrun_cnt != 8'hFF) begin
               overrun_cnt <= overrun_cnt + 8'd1;
            end
         end
      end
   end

   // DRP wait timer (down-counter, expires at zero) and sample capture
   always_ff @(posedge dclk_in) begin
      if (reset_in) begin
         tmo_q    <= '0;
         sample_q <= '0;
      end else begin
         if (state_q == ST_REQ) begin
            tmo_q <= TMO_LOAD;
         end else if (state_q == ST_WAIT && tmo_q != '0) begin
            tmo_q <= tmo_q - 1'b1;
         end

         if (state_q == ST_WAIT && drdy_in) begin
            sample_q <= do_in[15 -: ADC_BITS];
         end
      end
   end

   // Accumulate the current slot, decide whether this sample closes the
   // average, and flag out-of-window results
   always_comb begin
      acc_sum   = acc_q[slot] + AW'(sample_q);
      avg_val   = acc_sum[AVG_LOG2 +: ADC_BITS];
      avg_last  = (cnt_q[slot] == CNT_LAST);
      res_wr    = (state_q == ST_ACC) && avg_last;
      alarm_set = '0;
      if (res_wr && ((avg_val > thr_hi) || (avg_val < thr_lo))) begin
         alarm_set[slot] = 1'b1;
      end
   end

   // Per-slot accumulator, sample counter and held result
   always_ff @(posedge dclk_in) begin
      if (reset_in) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else if (state_q == ST_ACC) begin
         cnt_q[slot] <= avg_last ? '0 : cnt_q[slot] + 1'b1;
         acc_q[slot] <= avg_last ? '0 : acc_sum;
         if (avg_last) begin
            res_q[slot] <= avg_val;
         end
      end
   end

   // Result strobe, last-write holding registers and sticky alarms; a set
   // takes priority over a simultaneous clear
   always_ff @(posedge dclk_in) begin
      if (reset_in) begin
         valid_out  <= 1'b0;
         valid_ch   <= '0;
         valid_data <= '0;
         alarm_out  <= '0;
      end else begin
         valid_out <= res_wr;
         if (res_wr) begin
            valid_ch   <= 4'(slot);
            valid_data <= avg_val;
         end
         alarm_out <= (alarm_out & ~{NUM_CH{alarm_clr}}) | alarm_set;
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_flat
      assign result_flat[gi*ADC_BITS +: ADC_BITS] = res_q[gi];
   end

   // Status-register bits below the result width carry no information here
   if (ADC_BITS < 16) begin : g_lsb
      logic unused_do_lsb;
      assign unused_do_lsb = ^do_in[15-ADC_BITS:0];
   end

endmodule

// File: tb/tb_xadc_chan_poller.sv
// Bench for xadc_chan_poller: one instance without averaging, one averaging
// over four samples. Results are checked by a scoreboard monitor; protocol
// timing, alarms, overrun and timeout are checked inline.

module tb_xadc_chan_poller;

   localparam int NB = 12;

   logic dclk_in = 1'b0;
   always #5 dclk_in = ~dclk_in;

   logic          reset_in;
   logic          eoc;
   logic          sel;
   logic          drdy;
   logic          alarm_clr;
   logic [4:0]    chan;
   logic [15:0]   do_d;
   logic [NB-1:0] thr_hi;
   logic [NB-1:0] thr_lo;

   logic eoc0, eoc1, drdy0, drdy1;
   assign eoc0  = eoc & ~sel;
   assign eoc1  = eoc & sel;
   assign drdy0 = drdy & ~sel;
   assign drdy1 = drdy & sel;

   logic          den0, den1, dwe0, dwe1, vld0, vld1;
   logic          busy0, busy1, tmo0, tmo1;
   logic [6:0]    daddr0, daddr1;
   logic [15:0]   di0, di1;
   logic [47:0]   res0, res1;
   logic [3:0]    vch0, vch1, alm0, alm1;
   logic [NB-1:0] vdat0, vdat1;
   logic [7:0]    ovr0, ovr1;

   logic       den_s, busy_s;
   logic [6:0] daddr_s;
   assign den_s   = sel ? den1 : den0;
   assign busy_s  = sel ? busy1 : busy0;
   assign daddr_s = sel ? daddr1 : daddr0;

   xadc_chan_poller #(.NUM_CH(4), .BASE_CH(16), .ADC_BITS(NB), .AVG_LOG2(0), .TIMEOUT(64)) u_dut0 (
      .dclk_in(dclk_in), .reset_in(reset_in), .eoc_in(eoc0), .channel_in(chan),
      .den_out(den0), .daddr_out(daddr0), .dwe_out(dwe0), .di_out(di0),
      .do_in(do_d), .drdy_in(drdy0), .thr_hi(thr_hi), .thr_lo(thr_lo),
      .alarm_clr(alarm_clr), .result_flat(res0), .valid_out(vld0),
      .valid_ch(vch0), .valid_data(vdat0), .alarm_out(alm0), .busy_out(busy0),
      .timeout_out(tmo0), .overrun_cnt(ovr0));

   xadc_chan_poller #(.NUM_CH(4), .BASE_CH(16), .ADC_BITS(NB), .AVG_LOG2(2), .TIMEOUT(64)) u_dut1 (
      .dclk_in(dclk_in), .reset_in(reset_in), .eoc_in(eoc1), .channel_in(chan),
      .den_out(den1), .daddr_out(daddr1), .dwe_out(dwe1), .di_out(di1),
      .do_in(do_d), .drdy_in(drdy1), .thr_hi(thr_hi), .thr_lo(thr_lo),
      .alarm_clr(alarm_clr), .result_flat(res1), .valid_out(vld1),
      .valid_ch(vch1), .valid_data(vdat1), .alarm_out(alm1), .busy_out(busy1),
      .timeout_out(tmo1), .overrun_cnt(ovr1));

   int cyc = 0;
   always @(posedge dclk_in) cyc <= cyc + 1;

   typedef struct {
      int            slot;
      logic [NB-1:0] data;
      logic [3:0]    alarm;
      int            exp_cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge dclk_in);
      #1;
   endtask

   task automatic push_exp(input int slot, input logic [NB-1:0] data, input logic [3:0] alm);
      exp_t e;
      e.slot    = slot;
      e.data    = data;
      e.alarm   = alm;
      e.exp_cyc = cyc + 2;
      if (sel) q1.push_back(e);
      else     q0.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge dclk_in);
         if (vld0) begin
            if (q0.size() == 0) begin
               check("dut0_unexpected_valid", vld0, 0);
            end else begin
               e = q0.pop_front();
               check("dut0_latency", cyc, e.exp_cyc);
               check("dut0_valid_ch", vch0, e.slot);
               check("dut0_valid_data", vdat0, e.data);
               check("dut0_result_slot", res0[e.slot*NB +: NB], e.data);
               check("dut0_alarm", alm0, e.alarm);
            end
         end else if (q0.size() != 0 && q0[0].exp_cyc <= cyc) begin
            check("dut0_missing_valid", vld0, 1);
            void'(q0.pop_front());
         end
         if (vld1) begin
            if (q1.size() == 0) begin
               check("dut1_unexpected_valid", vld1, 0);
            end else begin
               e = q1.pop_front();
               check("dut1_latency", cyc, e.exp_cyc);
               check("dut1_valid_ch", vch1, e.slot);
               check("dut1_valid_data", vdat1, e.data);
               check("dut1_result_slot", res1[e.slot*NB +: NB], e.data);
               check("dut1_alarm", alm1, e.alarm);
            end
         end else if (q1.size() != 0 && q1[0].exp_cyc <= cyc) begin
            check("dut1_missing_valid", vld1, 1);
            void'(q1.pop_front());
         end
      end
   endtask

   // One complete read: EOC, den pulse, gap WAIT cycles, drdy, ACC, back in IDLE
   task automatic do_read(input logic [4:0] ch, input logic [15:0] rd, input int gap,
                          input logic push, input logic [NB-1:0] exp_data,
                          input logic [3:0] exp_alm, input logic clr_acc);
      eoc  = 1'b1;
      chan = ch;
      tick();
      eoc = 1'b0;
      check("den_pulse", den_s, 1);
      check("daddr", daddr_s, {2'b00, ch});
      check("busy_req", busy_s, 1);
      tick();
      check("den_single", den_s, 0);
      repeat (gap) tick();
      drdy = 1'b1;
      do_d = rd;
      if (push) push_exp(int'(ch) - 16, exp_data, exp_alm);
      tick();
      drdy = 1'b0;
      do_d = '0;
      check("busy_acc", busy_s, 1);
      if (clr_acc) alarm_clr = 1'b1;
      tick();
      alarm_clr = 1'b0;
      check("busy_idle", busy_s, 0);
   endtask

   initial begin
      reset_in  = 1'b1;
      eoc       = 1'b0;
      sel       = 1'b0;
      drdy      = 1'b0;
      alarm_clr = 1'b0;
      chan      = '0;
      do_d      = '0;
      thr_hi    = 12'hFFF;
      thr_lo    = 12'h000;
      repeat (3) tick();
      check("rst_result", res0, 0);
      check("rst_valid", {vld0, vch0, vdat0}, 0);
      check("rst_ctrl", {den0, busy0, tmo0, daddr0}, 0);
      check("rst_alarm_ovr", {alm0, ovr0}, 0);
      check("rst_dut1", {res1, vld1, busy1, den1}, 0);
      reset_in = 1'b0;
      tick();
      fork
         monitor();
      join_none

      // basic read, drdy three cycles after den
      do_read(5'd17, 16'hABC0, 2, 1'b1, 12'hABC, 4'b0000, 1'b0);
      check("dwe_di_zero", {dwe0, di0}, 0);
      // minimum latency, first slot
      do_read(5'd16, 16'h0010, 0, 1'b1, 12'h001, 4'b0000, 1'b0);

      // out-of-range channels are ignored
      eoc = 1'b1; chan = 5'd3; tick(); eoc = 1'b0;
      check("oor_low_den", den0, 0);
      check("oor_low_busy", busy0, 0);
      eoc = 1'b1; chan = 5'd20; tick(); eoc = 1'b0;
      check("oor_high_den", den0, 0);
      check("oor_high_busy", busy0, 0);
      check("oor_no_overrun", ovr0, 0);
      do_read(5'd19, 16'h5550, 1, 1'b1, 12'h555, 4'b0000, 1'b0);

      // window alarms
      thr_hi = 12'h800;
      thr_lo = 12'h100;
      do_read(5'd18, 16'h9000, 1, 1'b1, 12'h900, 4'b0100, 1'b0);
      do_read(5'd18, 16'h4000, 1, 1'b1, 12'h400, 4'b0100, 1'b0);
      alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
      check("alarm_cleared", alm0, 0);
      do_read(5'd16, 16'h0500, 1, 1'b1, 12'h050, 4'b0001, 1'b0);
      do_read(5'd17, 16'h8000, 1, 1'b1, 12'h800, 4'b0001, 1'b0);
      do_read(5'd16, 16'h1000, 1, 1'b1, 12'h100, 4'b0001, 1'b0);
      do_read(5'd19, 16'hF000, 1, 1'b1, 12'hF00, 4'b1000, 1'b1);

      // pending slot and overrun: EOC 16 starts, 17 parks, 18 dropped
      eoc = 1'b1; chan = 5'd16; tick();
      chan = 5'd17; tick();
      chan = 5'd18; tick();
      eoc = 1'b0;
      check("ovr_one", ovr0, 1);
      drdy = 1'b1; do_d = 16'h1230; push_exp(0, 12'h123, 4'b1000); tick();
      drdy = 1'b0; do_d = '0; tick();
      // IDLE with pending full: live EOC 19 replaces the served entry
      check("pend_idle", busy0, 0);
      eoc = 1'b1; chan = 5'd19; tick();
      eoc = 1'b0;
      check("pend_den", den0, 1);
      check("pend_daddr", daddr0, 7'h11);
      tick();
      drdy = 1'b1; do_d = 16'h4560; push_exp(1, 12'h456, 4'b1000); tick();
      drdy = 1'b0; do_d = '0; tick();
      tick();
      check("live_pend_den", den0, 1);
      check("live_pend_daddr", daddr0, 7'h13);
      tick();
      drdy = 1'b1; do_d = 16'h7000; push_exp(3, 12'h700, 4'b1000); tick();
      drdy = 1'b0; do_d = '0; tick();
      check("pend_done_idle", busy0, 0);
      check("ovr_still_one", ovr0, 1);

      // DRP timeout
      eoc = 1'b1; chan = 5'd17; tick(); eoc = 1'b0;
      repeat (63) tick();
      check("tmo_early", tmo0, 0);
      check("tmo_busy", busy0, 1);
      tick();
      check("tmo_pulse", tmo0, 1);
      tick();
      check("tmo_single", tmo0, 0);
      check("tmo_idle", busy0, 0);
      drdy = 1'b1; do_d = 16'hEEE0; tick();
      drdy = 1'b0; do_d = '0; tick(); tick();
      check("tmo_no_result", res0[23:12], 12'h456);
      check("late_drdy_idle", busy0, 0);

      // overrun saturation
      eoc = 1'b1; chan = 5'd18;
      repeat (400) tick();
      eoc = 1'b0;
      repeat (150) tick();
      check("ovr_saturated", ovr0, 255);
      check("ovr_idle", busy0, 0);
      check("ovr_no_result", res0[35:24], 12'h400);

      // averaging instance
      sel = 1'b1;
      thr_hi = 12'hFFF;
      thr_lo = 12'h000;
      do_read(5'd16, 16'h0640, 1, 1'b0, '0, 4'b0000, 1'b0);
      do_read(5'd16, 16'h0650, 1, 1'b0, '0, 4'b0000, 1'b0);
      do_read(5'd16, 16'h0660, 1, 1'b0, '0, 4'b0000, 1'b0);
      do_read(5'd16, 16'h0680, 1, 1'b1, 12'h065, 4'b0000, 1'b0);
      do_read(5'd16, 16'h0080, 1, 1'b0, '0, 4'b0000, 1'b0);
      do_read(5'd16, 16'h0080, 1, 1'b0, '0, 4'b0000, 1'b0);
      do_read(5'd16, 16'h0080, 1, 1'b0, '0, 4'b0000, 1'b0);
      check("avg_held", res1[11:0], 12'h065);
      do_read(5'd16, 16'h0080, 1, 1'b1, 12'h008, 4'b0000, 1'b0);
      sel = 1'b0;

      // reset in the middle of a read
      thr_hi = 12'h800;
      thr_lo = 12'h100;
      eoc = 1'b1; chan = 5'd17; tick(); eoc = 1'b0;
      tick();
      check("pre_rst_busy", busy0, 1);
      reset_in = 1'b1; tick();
      check("mid_rst_result", res0, 0);
      check("mid_rst_valid", {vld0, vch0, vdat0}, 0);
      check("mid_rst_ctrl", {den0, busy0, tmo0, daddr0}, 0);
      check("mid_rst_alarm_ovr", {alm0, ovr0}, 0);
      reset_in = 1'b0;
      drdy = 1'b1; do_d = 16'hFFF0; tick();
      drdy = 1'b0; do_d = '0; tick(); tick();
      check("post_rst_idle", busy0, 0);
      check("post_rst_result", res0, 0);
      do_read(5'd17, 16'h3330, 1, 1'b1, 12'h333, 4'b0000, 1'b0);

      repeat (4) tick();
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xadc_chan_poller.md
# xadc_chan_poller

Parametrised XADC sampling engine between the XADC wizard's DRP/status pins and user logic. Each end-of-conversion issues a DRP read of the converted channel's status register, optionally box-car averages 2^AVG_LOG2 samples per channel, holds one result per channel, and raises sticky per-channel window alarms. It generalises the single-channel capture register to NUM_CH channels with averaging, a DRP timeout, and overrun accounting.

## Interface
- NUM_CH, 4: channels polled, 1..16; slot i = XADC channel BASE_CH+i
- BASE_CH, 16: first XADC channel index (16 = VAUX0), BASE_CH+NUM_CH <= 32
- ADC_BITS, 12: result width taken from do_in[15:16-ADC_BITS], 1..16
- AVG_LOG2, 0: samples averaged per result = 2^AVG_LOG2, 0..4
- TIMEOUT, 64: max dclk_in cycles waiting for drdy_in, >= 4

- dclk_in  in  1  clock; one clock, all logic on rising edge
- reset_in  in  1  synchronous, active-high reset
- eoc_in  in  1  XADC end-of-conversion pulse
- channel_in  in  5  XADC channel_out, valid with eoc_in
- den_out  out  1  DRP enable, one-cycle pulse
- daddr_out  out  7  DRP address = {2'b00, channel}
- dwe_out  out  1  DRP write enable, constant 0
- di_out  out  16  DRP write data, constant 0
- do_in  in  16  DRP read data, valid with drdy_in
- drdy_in  in  1  DRP data ready
- thr_hi  in  ADC_BITS  alarm upper bound (inclusive pass)
- thr_lo  in  ADC_BITS  alarm lower bound (inclusive pass)
- alarm_clr  in  1  clears all sticky alarms
- result_flat  out  NUM_CH*ADC_BITS  slot i at [i*ADC_BITS +: ADC_BITS]
- valid_out  out  1  one-cycle strobe: new result written
- valid_ch  out  4  slot index of the write (held between strobes)
- valid_data  out  ADC_BITS  value written (held between strobes)
- alarm_out  out  NUM_CH  sticky per-slot out-of-window flags
- busy_out  out  1  FSM not in IDLE
- timeout_out  out  1  one-cycle strobe: DRP read abandoned
- overrun_cnt  out  8  saturating count of dropped EOCs

## Operation
- FSM: IDLE, REQ, WAIT, ACC.
- IDLE: take pending EOC if set, else live eoc_in; a channel outside [BASE_CH, BASE_CH+NUM_CH-1] is discarded without count. In-range -> latch channel, go REQ.
- REQ: den_out=1, daddr_out={2'b00,ch} for exactly this cycle -> WAIT; timeout counter cleared.
- WAIT: drdy_in -> capture do_in[15:16-ADC_BITS] -> ACC. Counter reaching TIMEOUT-1 without drdy_in -> timeout_out pulse, sample discarded, -> IDLE.
- ACC: acc[slot] += sample (width ADC_BITS+AVG_LOG2, cannot overflow); cnt[slot]++. When cnt[slot] wraps to 0 (2^AVG_LOG2 samples): result = (acc+sample) >> AVG_LOG2 (truncation), write result slot, pulse valid_out, update valid_ch/valid_data, clear acc[slot]. AVG_LOG2=0 -> every sample written. -> IDLE.
- Alarm: on each result write, result > thr_hi or result < thr_lo sets alarm_out[slot]; never cleared by in-window results. alarm_clr clears all bits; a set on the same cycle as alarm_clr wins.
- EOC while not IDLE: stored in one-deep pending slot (channel latched). EOC arriving while pending already full: new EOC dropped, overrun_cnt++ (saturates 255). Pending and live EOC in same IDLE cycle: pending served, live goes to pending.
- drdy_in outside WAIT ignored.
- Reset: FSM IDLE; den_out, valid_out, timeout_out, busy_out, pending = 0; result_flat, accumulators, counters, valid_ch, valid_data, alarm_out, overrun_cnt = 0; daddr_out = 0. Reset mid-read abandons the read; late drdy_in ignored.

## Timing
- eoc_in at cycle t (IDLE, in range) -> den_out high at t+1 only.
- drdy_in at cycle d -> ACC at d+1 -> result_flat/valid_out/valid_data/alarm_out visible at d+2.
- Minimum EOC-to-valid_out latency = 4 cycles (drdy_in at t+2).
- busy_out high from t+1 through ACC cycle inclusive.
- Back-to-back: next den_out no earlier than 1 cycle after ACC (via IDLE).
- Timeout: drdy_in absent, timeout_out at t+1+TIMEOUT, IDLE next cycle.

## Test plan
- NUM_CH=4, AVG_LOG2=0: eoc_in ch=17, drdy_in 3 cycles after den_out with do_in=16'hABC0 -> daddr_out=7'h11, valid_ch=1, valid_data=12'hABC, result_flat[23:12]=12'hABC, valid_out 2 cycles after drdy_in.
- AVG_LOG2=2, ch 16 samples 100,101,102,104 (<<4) -> only 4th read strobes valid_out, valid_data=101; acc cleared, next 4 samples of 8 give 8.
- eoc_in ch=3 and ch=20 with NUM_CH=4 -> no den_out, no overrun; ch=19 read normally.
- Three EOCs during one WAIT -> first pending served, second dropped, overrun_cnt=1; 300 drops -> 255.
- No drdy_in, TIMEOUT=64 -> timeout_out pulse 64 cycles after den_out, no result change; late drdy_in ignored.
- thr_hi=12'h800, result 12'h900 -> alarm_out[slot]=1, stays after result 12'h400; alarm_clr -> 0; reset_in asserted during WAIT -> all outputs zero next cycle.
